uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit byte channel among NUM_REQ independent requesters, e.g. the AHB register path, a debug/test source and a DMA engine.
- Round-robin arbitration; a grant is held for a whole packet, delimited by a last flag.
- MAX_BURST bounds how long one requester can hold the channel.
- Sits between the byte producers and the UART controller's TX byte-input handshake.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit byte channel among NUM_REQ requesters.
// Round-robin arbitration picks an owner in IDLE. The owner then keeps the
// channel in XFER until it hands over a byte flagged last, or until it has
// moved MAX_BURST bytes in this grant. Bytes pass combinationally from the
// owner to the transmitter. Every grant is followed by one IDLE bubble
// cycle, so arbitration always sees a fresh view of the requesters.

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,   // number of requesters (2..8)
  parameter int DATA_BITS = 8,   // bits per UART character
  parameter int MAX_BURST = 16   // bytes per grant before forced release (1..255)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           burst_cut
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Pointer resets to the last index so that requester 0 wins first.
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [PTR_W-1:0]     rr_ptr;      // index of the most recent owner
  logic [PTR_W-1:0]     owner;       // binary index of the current owner
  logic [CNT_W-1:0]     count;       // bytes accepted in the current grant
  logic [CNT_W-1:0]     count_inc;

  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

  logic                 arb_found;
  logic [PTR_W-1:0]     arb_idx;
  logic [PTR_W:0]       cand;

  logic                 owner_valid;
  logic                 owner_last;
  logic                 handshake;
  logic                 at_limit;
  logic                 pkt_done;

  // Split the flat requester data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Round-robin search: first asserted req_valid upward from rr_ptr+1, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!arb_found && req_valid[cand[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Owner handshake and release decode for the XFER state.
  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign handshake   = (state == XFER) && owner_valid && tx_ready;
  assign count_inc   = count + CNT_W'(1);
  assign at_limit    = (count_inc == CNT_MAX);
  assign pkt_done    = handshake && (owner_last || at_limit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: grant on any request, release on last or burst limit.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (arb_found) state_next = XFER;
      XFER: if (pkt_done)  state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Grant, owner, round-robin pointer, byte count and burst_cut registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= PTR_RST;
      count     <= '0;
      burst_cut <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register here updating from
      // the pre-edge values, independent of statement order.
      burst_cut <= pkt_done && at_limit && !owner_last;
      unique case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= NUM_REQ'(1) << arb_idx;
            owner <= arb_idx;
            count <= '0;
          end
        end
        XFER: begin
          if (pkt_done) begin
            grant  <= '0;
            rr_ptr <= owner;
            count  <= '0;
          end else if (handshake) begin
            count  <= count_inc;
          end
        end
        default: begin
          grant <= '0;
        end
      endcase
    end
  end

  // Output logic: pass the owner's handshake straight through in XFER.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    busy      = 1'b0;
    if (state == XFER) begin
      busy             = 1'b1;
      tx_valid         = owner_valid;
      req_ready[owner] = tx_ready;
      if (owner_valid) begin
        tx_data = req_bytes[owner];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8, MAX_BURST=16).
// Part one applies a table of per-cycle input/expected-output records.
// Part two drives packet sources from queues; expected bytes are queued per
// requester when a packet is loaded and popped when the DUT transmits.

module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DB = 8;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DB-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            burst_cut;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_BITS (DB),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy),
    .burst_cut (burst_cut)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic          rst;
    logic [NR-1:0] valid;
    logic [31:0]   data;
    logic [NR-1:0] last;
    logic          tx_rdy;
    logic [NR-1:0] grant;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [NR-1:0] ready;
    logic          busy;
    logic          cut;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l,
                                  logic tr, logic [3:0] g, logic tv, logic [7:0] td,
                                  logic [3:0] rd, logic b, logic bc);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.last = l; x.tx_rdy = tr;
    x.grant = g; x.tx_valid = tv; x.tx_data = td; x.ready = rd; x.busy = b; x.cut = bc;
    vecs.push_back(x);
  endfunction

  // Cycle in which every output must be zero (reset or IDLE).
  function automatic void add_idle(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l);
    add_vec(r, v, d, l, 1'b1, 4'b0, 1'b0, 8'h00, 4'b0, 1'b0, 1'b0);
  endfunction

  function automatic void build_table();
    // 3-byte packet from requester 0, with one tx_ready stall on byte 2.
    add_idle(1, 4'b0000, 32'h0, 4'b0000);
    add_idle(0, 4'b0001, 32'h000000A1, 4'b0000);
    add_vec (0, 4'b0001, 32'h000000A1, 4'b0000, 1, 4'b0001, 1, 8'hA1, 4'b0001, 1, 0);
    add_vec (0, 4'b0001, 32'h000000A2, 4'b0000, 0, 4'b0001, 1, 8'hA2, 4'b0000, 1, 0);
    add_vec (0, 4'b0001, 32'h000000A2, 4'b0000, 1, 4'b0001, 1, 8'hA2, 4'b0001, 1, 0);
    add_vec (0, 4'b0001, 32'h000000A3, 4'b0001, 1, 4'b0001, 1, 8'hA3, 4'b0001, 1, 0);
    add_idle(0, 4'b0000, 32'h0, 4'b0000);
    add_idle(0, 4'b0000, 32'h0, 4'b0000);
    // All four requesters with 1-byte packets: order 0,1,2,3,0 with bubbles.
    add_idle(1, 4'b0000, 32'h0, 4'b0000);
    add_idle(0, 4'b1111, 32'h13121110, 4'b1111);
    add_vec (0, 4'b1111, 32'h13121110, 4'b1111, 1, 4'b0001, 1, 8'h10, 4'b0001, 1, 0);
    add_idle(0, 4'b1111, 32'h13121120, 4'b1111);
    add_vec (0, 4'b1111, 32'h13121120, 4'b1111, 1, 4'b0010, 1, 8'h11, 4'b0010, 1, 0);
    add_idle(0, 4'b1101, 32'h13121120, 4'b1111);
    add_vec (0, 4'b1101, 32'h13121120, 4'b1111, 1, 4'b0100, 1, 8'h12, 4'b0100, 1, 0);
    add_idle(0, 4'b1001, 32'h13121120, 4'b1111);
    add_vec (0, 4'b1001, 32'h13121120, 4'b1111, 1, 4'b1000, 1, 8'h13, 4'b1000, 1, 0);
    add_idle(0, 4'b0001, 32'h13121120, 4'b1111);
    add_vec (0, 4'b0001, 32'h13121120, 4'b1111, 1, 4'b0001, 1, 8'h20, 4'b0001, 1, 0);
    add_idle(0, 4'b0000, 32'h0, 4'b0000);
    // Reset during byte 2 from requester 3 while requester 0 is pending.
    add_idle(1, 4'b0000, 32'h0, 4'b0000);
    add_idle(0, 4'b1000, 32'h40000000, 4'b0000);
    add_vec (0, 4'b1000, 32'h40000000, 4'b0000, 1, 4'b1000, 1, 8'h40, 4'b1000, 1, 0);
    add_idle(1, 4'b1001, 32'h41000050, 4'b0001);
    add_idle(0, 4'b1001, 32'h40000050, 4'b1001);
    add_vec (0, 4'b1001, 32'h40000050, 4'b1001, 1, 4'b0001, 1, 8'h50, 4'b0001, 1, 0);
    add_idle(0, 4'b1000, 32'h40000000, 4'b1000);
    add_vec (0, 4'b1000, 32'h40000000, 4'b1000, 1, 4'b1000, 1, 8'h40, 4'b1000, 1, 0);
    add_idle(0, 4'b0000, 32'h0, 4'b0000);
    // Last byte from requester 0 while requester 1 waits: bubble, then grant 1.
    add_idle(1, 4'b0000, 32'h0, 4'b0000);
    add_idle(0, 4'b0011, 32'h00003130, 4'b0011);
    add_vec (0, 4'b0011, 32'h00003130, 4'b0011, 1, 4'b0001, 1, 8'h30, 4'b0001, 1, 0);
    add_idle(0, 4'b0010, 32'h00003100, 4'b0010);
    add_vec (0, 4'b0010, 32'h00003100, 4'b0010, 1, 4'b0010, 1, 8'h31, 4'b0010, 1, 0);
    add_idle(0, 4'b0000, 32'h0, 4'b0000);
  endfunction

  // ---------------------------------------------------------- scoreboard
  logic [8:0]    src_q [NR][$];   // bytes still to be offered, {last, data}
  logic [8:0]    exp_q [NR][$];   // bytes still expected on tx_data
  bit            hold_off [NR];
  logic          tx_rdy_drv;
  int            hs_cnt [NR];
  int            hs_total;
  int            bc_cnt;
  int            bc_at;
  int            grant_log[$];
  logic [NR-1:0] prev_grant;
  logic [NR-1:0] s_grant;
  logic [NR-1:0] s_ready;
  logic          s_tv;

  function automatic int oh_idx(logic [NR-1:0] g);
    int idx = -1;
    if ($onehot(g)) begin
      for (int i = 0; i < NR; i++) if (g[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int log_at(int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic bit drained();
    bit d = 1'b1;
    for (int r = 0; r < NR; r++) if (src_q[r].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic sb_reset();
    for (int r = 0; r < NR; r++) begin
      src_q[r].delete();
      exp_q[r].delete();
      hold_off[r] = 1'b0;
      hs_cnt[r]   = 0;
    end
    grant_log.delete();
    hs_total = 0; bc_cnt = 0; bc_at = -1; prev_grant = '0;
    tx_rdy_drv = 1'b1;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_pkt(input int r, input int n, input logic [7:0] base, input int last_at);
    logic [8:0] b;
    for (int i = 1; i <= n; i++) begin
      b = {(i == last_at), 8'(base + 8'(i - 1))};
      src_q[r].push_back(b);
      exp_q[r].push_back(b);
    end
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later, retire handshakes.
  task automatic sb_cycle();
    logic [8:0] head;
    logic [8:0] e;
    int         own;
    for (int r = 0; r < NR; r++) begin
      head = (src_q[r].size() != 0) ? src_q[r][0] : 9'h0;
      req_valid[r]         = (src_q[r].size() != 0) && !hold_off[r];
      req_data[r*DB +: DB] = head[7:0];
      req_last[r]          = head[8];
    end
    tx_ready = tx_rdy_drv;
    #1;
    s_grant = grant; s_ready = req_ready; s_tv = tx_valid;
    if (burst_cut) begin
      bc_cnt++;
      bc_at = hs_total;
    end
    if (grant != '0 && prev_grant == '0) grant_log.push_back(oh_idx(grant));
    prev_grant = grant;
    if (tx_valid && tx_ready) begin
      own = oh_idx(grant);
      check("sb_grant_onehot", own >= 0, 1'b1);
      if (own >= 0) begin
        check("sb_ready", req_ready, grant);
        check("sb_byte_pending", exp_q[own].size() != 0, 1'b1);
        if (exp_q[own].size() != 0) begin
          e = exp_q[own].pop_front();
          check($sformatf("sb_byte_req%0d", own), tx_data, e[7:0]);
        end
        hs_cnt[own]++;
        hs_total++;
      end
    end
    for (int r = 0; r < NR; r++) begin
      if (req_valid[r] && req_ready[r] && src_q[r].size() != 0) void'(src_q[r].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run_until_drained(input string name, input int budget);
    int c = 0;
    while (!drained() && c < budget) begin
      sb_cycle();
      c++;
    end
    check({name, "_timeout"}, drained(), 1'b1);
    repeat (3) sb_cycle();
  endtask

  // -------------------------------------------------------------- main
  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    build_table();
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      req_last  = vecs[i].last;
      tx_ready  = vecs[i].tx_rdy;
      #1;
      check($sformatf("vec%0d {grant,tx_valid,tx_data,req_ready,busy,burst_cut}", i),
            {grant, tx_valid, tx_data, req_ready, busy, burst_cut},
            {vecs[i].grant, vecs[i].tx_valid, vecs[i].tx_data, vecs[i].ready,
             vecs[i].busy, vecs[i].cut});
      @(negedge clk);
    end

    // Requester 2 streams 20 bytes: cut after byte 16, re-granted for 17..20.
    sb_reset();
    load_pkt(2, 20, 8'h60, 20);
    run_until_drained("burst", 100);
    check("burst_cut_count", bc_cnt, 1);
    check("burst_cut_after_byte", bc_at, 16);
    check("burst_bytes", hs_cnt[2], 20);
    check("burst_grants", {32'(grant_log.size()), 32'(log_at(0))}, {32'd2, 32'd2});
    check("burst_regrant", log_at(1), 2);
    check("burst_exp_left", exp_q[2].size(), 0);

    // Last flag on byte 16 coincides with the limit: no burst_cut.
    sb_reset();
    load_pkt(2, 16, 8'h90, 16);
    run_until_drained("coincide", 60);
    check("coincide_no_cut", bc_cnt, 0);
    check("coincide_grants", grant_log.size(), 1);
    check("coincide_exp_left", exp_q[2].size(), 0);

    // Owner 1 stalls on tx_ready, then on its own valid, while 3 waits.
    sb_reset();
    load_pkt(1, 4, 8'h71, 4);
    load_pkt(3, 1, 8'h80, 1);
    for (int c = 0; c < 10 && hs_cnt[1] < 1; c++) sb_cycle();
    check("stall_first_byte", hs_cnt[1], 1);
    tx_rdy_drv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sb_cycle();
      check("stall_txrdy_grant", s_grant, 4'b0010);
      check("stall_txrdy_ready", s_ready, 4'b0000);
    end
    tx_rdy_drv = 1'b1;
    hold_off[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sb_cycle();
      check("stall_valid_grant", s_grant, 4'b0010);
      check("stall_valid_txvalid", s_tv, 1'b0);
      check("stall_valid_ready", s_ready, 4'b0010);
    end
    check("stall_no_handshake", hs_total, 1);
    hold_off[1] = 1'b0;
    run_until_drained("stall", 60);
    check("stall_bytes_req1", hs_cnt[1], 4);
    check("stall_bytes_req3", hs_cnt[3], 1);
    check("stall_grant_order", {32'(log_at(0)), 32'(log_at(1))}, {32'd1, 32'd3});
    check("stall_exp_left", exp_q[1].size() + exp_q[3].size(), 0);
    check("stall_no_cut", bc_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, required to finish earlier");
    $fatal(1);
  end

endmodule
